// File: rtl/tone_gen_pkg.sv
// Shared types and helpers for the multi-channel tone generator.
package tone_gen_pkg;

   // Width of the stored per-channel config words; CNT_W fields are zero-extended into it.
   localparam int CFG_W = 32;

   typedef enum logic {
      PH_HIGH = 1'b0,
      PH_LOW  = 1'b1
   } phase_e;

   typedef struct packed {
      logic             en;
      logic [CFG_W-1:0] hi;
      logic [CFG_W-1:0] lo;
   } ch_cfg_t;

   // Per-channel mixer amplitude; NUM_CH of these summed can never overflow SAMPLE_W.
   function automatic int calc_amp(input int sample_w, input int num_ch);
      return ((1 << (sample_w - 1)) / num_ch) - 1;
   endfunction

   // Half period of a 440 Hz tone in clock cycles.
   function automatic int calc_default_half(input int clk_hz);
      return clk_hz / 440 / 2;
   endfunction

endpackage

// File: rtl/tone_gen_channel.sv
// One tone channel: phase FSM, down-counter and a single pending config slot.
module tone_gen_channel
   import tone_gen_pkg::*;
#(
   parameter logic             RST_EN   = 1'b0,
   parameter logic [CFG_W-1:0] RST_HALF = '0
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             wr_i,
   input  logic             en_i,
   input  logic [CFG_W-1:0] hi_i,
   input  logic [CFG_W-1:0] lo_i,
   output logic             en_o,
   output logic             audio_o,
   output logic             pend_o
);

   localparam logic [CFG_W-1:0] ONE     = CFG_W'(1);
   localparam ch_cfg_t          RST_CFG = '{en: RST_EN, hi: RST_HALF, lo: RST_HALF};
   localparam logic [CFG_W-1:0] RST_CNT = (RST_HALF != '0) ? (RST_HALF - ONE) : '0;

   ch_cfg_t          act_q, act_d, pend_q, pend_d, wcfg;
   phase_e           ph_q, ph_d;
   logic [CFG_W-1:0] cnt_q, cnt_d;
   logic             pvld_q, pvld_d;
   logic             audio_q, audio_d;
   logic             toggling, steady;

   // A zero-length high phase is skipped, so such a config starts in LOW.
   function automatic phase_e start_ph(input ch_cfg_t c);
      return (c.hi == '0) ? PH_LOW : PH_HIGH;
   endfunction

   function automatic logic [CFG_W-1:0] start_cnt(input ch_cfg_t c);
      if (c.hi != '0)      return c.hi - ONE;
      else if (c.lo != '0) return c.lo - ONE;
      else                 return '0;
   endfunction

   // Next-state: count the current phase, swap in pending config at end of period, take writes.
   always_comb begin
      act_d    = act_q;
      ph_d     = ph_q;
      cnt_d    = cnt_q;
      pend_d   = pend_q;
      pvld_d   = pvld_q;
      wcfg     = '{en: en_i, hi: hi_i, lo: lo_i};
      toggling = act_q.en && (act_q.hi != '0) && (act_q.lo != '0);
      steady   = act_q.en && ((act_q.hi != '0) != (act_q.lo != '0));
      if (toggling) begin
         if (cnt_q != '0) begin
            cnt_d = cnt_q - ONE;
         end else if (ph_q == PH_HIGH) begin
            ph_d  = PH_LOW;
            cnt_d = act_q.lo - ONE;
         end else if (pvld_q) begin
            act_d  = pend_q;
            ph_d   = start_ph(pend_q);
            cnt_d  = start_cnt(pend_q);
            pvld_d = 1'b0;
         end else begin
            ph_d  = PH_HIGH;
            cnt_d = act_q.hi - ONE;
         end
      end else if (steady && (cnt_q != '0)) begin
         cnt_d = cnt_q - ONE;
      end
      // A toggling channel defers writes (including disables) to avoid runt pulses.
      if (wr_i) begin
         if (toggling) begin
            pend_d = wcfg;
            pvld_d = 1'b1;
         end else begin
            act_d = wcfg;
            ph_d  = start_ph(wcfg);
            cnt_d = start_cnt(wcfg);
         end
      end
      audio_d = act_d.en && (ph_d == PH_HIGH) && (act_d.hi != '0);
   end

   // State registers; audio is registered from the next state so it lines up with the phase.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         act_q   <= RST_CFG;
         ph_q    <= PH_HIGH;
         cnt_q   <= RST_CNT;
         pend_q  <= '0;
         pvld_q  <= 1'b0;
         audio_q <= 1'b0;
      end else begin
         act_q   <= act_d;
         ph_q    <= ph_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         pvld_q  <= pvld_d;
         audio_q <= audio_d;
      end
   end

   assign en_o    = act_q.en;
   assign audio_o = audio_q;
   assign pend_o  = pvld_q;

endmodule

// File: rtl/tone_gen_multi.sv
// Multi-channel square-wave tone generator with config decode and PCM mixer.
module tone_gen_multi
   import tone_gen_pkg::*;
#(
   parameter int CLK_HZ       = 100_000_000,
   parameter int NUM_CH       = 4,
   parameter int CNT_W        = 32,
   parameter int SAMPLE_W     = 16,
   parameter int SAMPLE_DIV   = 2272,
   parameter int DEFAULT_HALF = calc_default_half(CLK_HZ)
) (
   input  logic                                         clk,
   input  logic                                         reset,
   input  logic                                         cfg_valid,
   output logic                                         cfg_ready,
   input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
   input  logic                                         cfg_en,
   input  logic [CNT_W-1:0]                             cfg_hi,
   input  logic [CNT_W-1:0]                             cfg_lo,
   output logic [NUM_CH-1:0]                            audio,
   output logic [SAMPLE_W-1:0]                          sample,
   output logic                                         sample_valid
);

   localparam int                   CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int                   DIV_W = $clog2(SAMPLE_DIV);
   localparam logic [DIV_W-1:0]     LAST  = DIV_W'(SAMPLE_DIV - 1);
   localparam logic signed [SAMPLE_W-1:0] AMP = SAMPLE_W'(calc_amp(SAMPLE_W, NUM_CH));

   logic [NUM_CH-1:0]          wr, ch_en, ch_pend;
   logic [CFG_W-1:0]           hi_w, lo_w;
   logic [DIV_W-1:0]           div_q;
   logic                       div_wrap;
   logic signed [SAMPLE_W-1:0] mix_sum, sample_q;
   logic                       sample_valid_q;

   assign hi_w = CFG_W'(cfg_hi);
   assign lo_w = CFG_W'(cfg_lo);

   // Ready reflects only the addressed channel's pending slot.
   always_comb begin
      cfg_ready = 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
         if (cfg_ch == CH_W'(i)) cfg_ready = !ch_pend[i];
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      assign wr[g] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(g));
      tone_gen_channel #(
         .RST_EN   ((g == 0) ? 1'b1 : 1'b0),
         .RST_HALF ((g == 0) ? CFG_W'(DEFAULT_HALF) : '0)
      ) u_ch (
         .clk_i   (clk),
         .reset_i (reset),
         .wr_i    (wr[g]),
         .en_i    (cfg_en),
         .hi_i    (hi_w),
         .lo_i    (lo_w),
         .en_o    (ch_en[g]),
         .audio_o (audio[g]),
         .pend_o  (ch_pend[g])
      );
   end

   // Mix: +AMP for a high channel, -AMP for an enabled low channel, nothing when disabled.
   always_comb begin
      mix_sum = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (audio[i])      mix_sum = mix_sum + AMP;
         else if (ch_en[i]) mix_sum = mix_sum - AMP;
      end
   end

   assign div_wrap = (div_q == LAST);

   // Free-running sample divider; the mixed value is captured at wrap with a one-cycle strobe.
   always_ff @(posedge clk) begin
      if (reset) begin
         div_q          <= '0;
         sample_q       <= '0;
         sample_valid_q <= 1'b0;
      end else begin
         sample_valid_q <= div_wrap;
         if (div_wrap) begin
            div_q    <= '0;
            sample_q <= mix_sum;
         end else begin
            div_q <= div_q + DIV_W'(1);
         end
      end
   end

   assign sample       = sample_q;
   assign sample_valid = sample_valid_q;

endmodule
